// File: rtl/warmboot_if.sv
// warmboot_if: board-side signals between the bootloader core,
// the PLL, the flash/USB monitors and the warm-boot sequencer.
interface warmboot_if;
  logic       pll_lock;
  logic       boot_req;
  logic [1:0] image_sel;
  logic       spi_cs_n;
  logic       usb_activity;
  logic       core_reset;
  logic       usb_pu;
  logic [1:0] wb_s;
  logic       wb_boot;
  logic       busy_booting;

  modport master (
    output pll_lock,
    output boot_req,
    output image_sel,
    output spi_cs_n,
    output usb_activity,
    input  core_reset,
    input  usb_pu,
    input  wb_s,
    input  wb_boot,
    input  busy_booting
  );

  modport slave (
    input  pll_lock,
    input  boot_req,
    input  image_sel,
    input  spi_cs_n,
    input  usb_activity,
    output core_reset,
    output usb_pu,
    output wb_s,
    output wb_boot,
    output busy_booting
  );
endinterface

// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: PLL-lock bring-up and SB_WARMBOOT exit sequencer.
// Define WARMBOOT_TIMEOUT_EN to add the idle auto-boot timer.
module warmboot_ctrl #(
  parameter logic [31:0] LOCK_CYCLES    = 32'd4096,
  parameter logic [31:0] DETACH_CYCLES  = 32'd480000,
  parameter logic [31:0] SETUP_CYCLES   = 32'd16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd480000000,
  parameter logic [1:0]  TIMEOUT_IMAGE  = 2'b01
) (
  input logic       clk_48mhz,
  input logic       reset,
  warmboot_if.slave bus
);

  typedef enum logic [2:0] {
    LOCK_WAIT,
    RUN,
    DRAIN,
    DETACH,
    SETUP,
    BOOT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] cnt;
  logic [31:0] cnt_nx;
  logic [1:0]  img;
  logic [1:0]  img_nx;
  logic        start;
  logic [1:0]  start_img;

`ifdef WARMBOOT_TIMEOUT_EN
  logic [31:0] idle;
  logic [31:0] idle_nx;
  logic        tmo;

  // Idle time only accumulates in RUN; a strobe restarts it.
  assign tmo = (state == RUN) && !bus.usb_activity
             && (idle == TIMEOUT_CYCLES - 32'd1);
  assign start     = bus.boot_req || tmo;
  assign start_img = bus.boot_req ? bus.image_sel : TIMEOUT_IMAGE;

  always_comb begin
    idle_nx = idle + 32'd1;
    if (state != RUN || bus.usb_activity)
      idle_nx = '0;
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) idle <= '0;
    else       idle <= idle_nx;
  end
`else
  logic unused_tmo;

  assign start      = bus.boot_req;
  assign start_img  = bus.image_sel;
  assign unused_tmo = ^{TIMEOUT_CYCLES, TIMEOUT_IMAGE,
                        bus.usb_activity};
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    img_nx   = img;
    unique case (state)
      LOCK_WAIT: begin
        if (!bus.pll_lock) begin
          cnt_nx = '0;
        end else if (cnt == LOCK_CYCLES - 32'd1) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      RUN: begin
        // Lock loss outranks any boot request.
        if (!bus.pll_lock) begin
          state_nx = LOCK_WAIT;
        end else if (start) begin
          state_nx = DRAIN;
          img_nx   = start_img;
        end
      end
      DRAIN: begin
        if (bus.spi_cs_n)
          state_nx = DETACH;
      end
      DETACH: begin
        if (cnt == DETACH_CYCLES - 32'd1) begin
          state_nx = SETUP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      SETUP: begin
        if (cnt == SETUP_CYCLES - 32'd1) begin
          state_nx = BOOT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      BOOT: begin
        state_nx = BOOT;
      end
      default: begin
        state_nx = LOCK_WAIT;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the current state, one edge behind it.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state            <= LOCK_WAIT;
      cnt              <= '0;
      img              <= 2'b00;
      bus.core_reset   <= 1'b1;
      bus.usb_pu       <= 1'b0;
      bus.wb_s         <= 2'b00;
      bus.wb_boot      <= 1'b0;
      bus.busy_booting <= 1'b0;
    end else begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      img              <= img_nx;
      bus.core_reset   <= (state == LOCK_WAIT);
      bus.usb_pu       <= (state != LOCK_WAIT)
                       && (state != DETACH);
      bus.wb_s         <= img;
      bus.wb_boot      <= (state == BOOT);
      bus.busy_booting <= state inside {DRAIN, DETACH,
                                        SETUP, BOOT};
    end
  end

endmodule

// File: tb/tb_warmboot_ctrl.sv
// tb_warmboot_ctrl: directed bench with an edge-timestamp model
// of the boot sequence checked every cycle.
module tb_warmboot_ctrl;

  localparam int LOCK = 8;
  localparam int DET  = 20;
  localparam int SET  = 4;
  localparam int TO   = 50;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  warmboot_if bus();

  warmboot_ctrl #(
    .LOCK_CYCLES   (32'd8),
    .DETACH_CYCLES (32'd20),
    .SETUP_CYCLES  (32'd4),
    .TIMEOUT_CYCLES(32'd50),
    .TIMEOUT_IMAGE (2'b01)
  ) dut (
    .clk_48mhz(clk),
    .reset    (reset),
    .bus      (bus)
  );

  function automatic void chk(input string nm,
                              input logic [1:0] act,
                              input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // Model: phase 0 locking, 1 running, 2 committed.
  // Expected outputs after edge n follow from the edge
  // numbers at which lock, request and flash-free occurred.
  int         n     = 0;
  int         phase = 0;
  int         run   = 0;
  int         since = 0;
  int         rq    = 0;
  int         d     = -1;
  logic [1:0] img_m = 2'b00;
  logic       e_core = 1'b1;
  logic       e_pu   = 1'b0;
  logic       e_boot = 1'b0;
  logic       e_busy = 1'b0;
  logic [1:0] e_s    = 2'b00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  = 0;
      run    = 0;
      d      = -1;
      img_m  = 2'b00;
      e_core = 1'b1;
      e_pu   = 1'b0;
      e_boot = 1'b0;
      e_busy = 1'b0;
      e_s    = 2'b00;
    end else begin
      n++;
      e_core = (phase == 0);
      e_busy = (phase == 2);
      e_s    = (phase == 2) ? img_m : 2'b00;
      e_pu   = (phase == 1) || (phase == 2 &&
               !(d >= 0 && n > d && n <= d + DET));
      e_boot = (phase == 2) && d >= 0 && n > d + DET + SET;
      case (phase)
        0: begin
          if (bus.pll_lock) begin
            run++;
            if (run == LOCK) begin
              phase = 1;
              since = n;
            end
          end else begin
            run = 0;
          end
        end
        1: begin
          if (!bus.pll_lock) begin
            phase = 0;
            run   = 0;
          end else if (bus.boot_req) begin
            phase = 2;
            img_m = bus.image_sel;
            d     = -1;
            rq    = n;
          end
`ifdef WARMBOOT_TIMEOUT_EN
          else if (bus.usb_activity) begin
            since = n;
          end else if (n - since == TO) begin
            phase = 2;
            img_m = 2'b01;
            d     = -1;
            rq    = n;
          end
`endif
        end
        default: begin
          if (d < 0 && n > rq && bus.spi_cs_n)
            d = n;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("core_reset", {1'b0, bus.core_reset}, {1'b0, e_core});
      chk("usb_pu", {1'b0, bus.usb_pu}, {1'b0, e_pu});
      chk("wb_boot", {1'b0, bus.wb_boot}, {1'b0, e_boot});
      chk("busy", {1'b0, bus.busy_booting}, {1'b0, e_busy});
      chk("wb_s", bus.wb_s, e_s);
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst core_reset", {1'b0, bus.core_reset}, 2'b01);
    chk("rst usb_pu", {1'b0, bus.usb_pu}, 2'b00);
    chk("rst wb_boot", {1'b0, bus.wb_boot}, 2'b00);
    chk("rst busy", {1'b0, bus.busy_booting}, 2'b00);
    chk("rst wb_s", bus.wb_s, 2'b00);
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    bus.pll_lock     = 1'b0;
    bus.boot_req     = 1'b0;
    bus.image_sel    = 2'b00;
    bus.spi_cs_n     = 1'b1;
    bus.usb_activity = 1'b0;
    #1;
    do_reset();

    // Bring-up: lock from edge 0, release at edge 8.
    bus.pll_lock = 1'b1;
    tick(8);
    chk("lock e7 core_reset", {1'b0, bus.core_reset}, 2'b01);
    chk("lock e7 usb_pu", {1'b0, bus.usb_pu}, 2'b00);
    tick(1);
    chk("lock e8 core_reset", {1'b0, bus.core_reset}, 2'b00);
    chk("lock e8 usb_pu", {1'b0, bus.usb_pu}, 2'b01);

    // Lock loss with simultaneous boot_req: loss wins.
    bus.pll_lock = 1'b0;
    bus.boot_req = 1'b1;
    bus.image_sel = 2'b11;
    tick(2);
    chk("loss core_reset", {1'b0, bus.core_reset}, 2'b01);
    chk("loss busy", {1'b0, bus.busy_booting}, 2'b00);
    bus.boot_req = 1'b0;
    bus.image_sel = 2'b00;

    // Glitch at count 5 restarts the lock count.
    bus.pll_lock = 1'b1;
    tick(5);
    bus.pll_lock = 1'b0;
    tick(1);
    bus.pll_lock = 1'b1;
    tick(8);
    chk("glitch e7 core_reset", {1'b0, bus.core_reset}, 2'b01);
    tick(1);
    chk("glitch e8 core_reset", {1'b0, bus.core_reset}, 2'b00);

    // Boot while flash busy for 10 cycles.
    bus.spi_cs_n  = 1'b0;
    bus.boot_req  = 1'b1;
    bus.image_sel = 2'b10;
    tick(1);
    bus.boot_req  = 1'b0;
    bus.image_sel = 2'b00;
    chk("R wb_s", bus.wb_s, 2'b00);
    tick(1);
    chk("R+1 wb_s", bus.wb_s, 2'b10);
    chk("R+1 busy", {1'b0, bus.busy_booting}, 2'b01);
    tick(8);
    bus.spi_cs_n = 1'b1;
    tick(1);
    chk("cs edge usb_pu", {1'b0, bus.usb_pu}, 2'b01);
    tick(1);
    chk("detach start usb_pu", {1'b0, bus.usb_pu}, 2'b00);
    tick(19);
    chk("detach end usb_pu", {1'b0, bus.usb_pu}, 2'b00);
    tick(1);
    chk("after detach usb_pu", {1'b0, bus.usb_pu}, 2'b01);
    tick(3);
    chk("fall+23 wb_boot", {1'b0, bus.wb_boot}, 2'b00);
    tick(1);
    chk("fall+24 wb_boot", {1'b0, bus.wb_boot}, 2'b01);

    // Committed sequence ignores lock, request and image.
    do_reset();
    tick(9);
    bus.boot_req  = 1'b1;
    bus.image_sel = 2'b11;
    tick(1);
    bus.boot_req  = 1'b0;
    bus.image_sel = 2'b00;
    tick(1);
    chk("commit wb_s", bus.wb_s, 2'b11);
    tick(3);
    bus.pll_lock = 1'b0;
    bus.boot_req = 1'b1;
    tick(10);
    chk("commit wb_s held", bus.wb_s, 2'b11);
    chk("commit core_reset", {1'b0, bus.core_reset}, 2'b00);
    bus.boot_req = 1'b0;
    tick(11);
    chk("commit R+25 wb_boot", {1'b0, bus.wb_boot}, 2'b00);
    tick(1);
    chk("commit R+26 wb_boot", {1'b0, bus.wb_boot}, 2'b01);

    // Reset in the middle of DETACH.
    bus.pll_lock = 1'b1;
    do_reset();
    tick(9);
    bus.boot_req  = 1'b1;
    bus.image_sel = 2'b10;
    tick(1);
    bus.boot_req  = 1'b0;
    bus.image_sel = 2'b00;
    tick(5);
    chk("mid detach usb_pu", {1'b0, bus.usb_pu}, 2'b00);
    do_reset();
    tick(8);
    chk("relock e7 core_reset", {1'b0, bus.core_reset}, 2'b01);
    tick(1);
    chk("relock e8 core_reset", {1'b0, bus.core_reset}, 2'b00);
    chk("relock e8 usb_pu", {1'b0, bus.usb_pu}, 2'b01);

`ifdef WARMBOOT_TIMEOUT_EN
    tick(30);
    bus.usb_activity = 1'b1;
    tick(1);
    bus.usb_activity = 1'b0;
    tick(50);
    chk("tmo A+50 busy", {1'b0, bus.busy_booting}, 2'b00);
    tick(1);
    chk("tmo A+51 busy", {1'b0, bus.busy_booting}, 2'b01);
    chk("tmo wb_s", bus.wb_s, 2'b01);
`else
    tick(1000);
    chk("idle busy", {1'b0, bus.busy_booting}, 2'b00);
    chk("idle usb_pu", {1'b0, bus.usb_pu}, 2'b01);
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
